// File: rtl/pulse_count_pkg.sv
// Shared types for the pulse-width capture stage: default sizes, the queued
// entry layout and the counter strobe-priority encoding.
package pulse_count_pkg;

    localparam int DEF_CNT_W  = 16;
    localparam int DEF_DEPTH  = 4;
    localparam int DEF_DROP_W = 8;

    typedef struct packed {
        logic                 sat;
        logic [DEF_CNT_W-1:0] width;
    } pw_entry_t;

    typedef enum logic [1:0] {
        STB_CLR  = 2'd0,
        STB_CAP  = 2'd1,
        STB_INC  = 2'd2,
        STB_HOLD = 2'd3
    } strobe_e;

    // SCLR > LOAD > INC; the FSM never overlaps them, but the order is fixed here.
    function automatic strobe_e strobe_decode(input logic sclr, input logic load,
                                              input logic inc);
        strobe_e s;
        if (sclr)      s = STB_CLR;
        else if (load) s = STB_CAP;
        else if (inc)  s = STB_INC;
        else           s = STB_HOLD;
        return s;
    endfunction

endpackage

// File: rtl/pulse_fifo.sv
// First-word-fall-through result queue. The head is kept in its own register
// so the output holds its last value once the queue drains.
module pulse_fifo #(
    parameter int W     = 17,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     push_i,
    input  logic [W-1:0]             din_i,
    input  logic                     pop_i,
    output logic [W-1:0]             dout_o,
    output logic                     valid_o,
    output logic                     full_o,
    output logic                     push_ok_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q, rd_nxt;
    logic [LW-1:0] level_q, level_d;
    logic [W-1:0]  head_q, head_d;
    logic          empty, full, pop_ok, push_ok;

    assign empty   = (level_q == '0);
    assign full    = (level_q == LW'(DEPTH));
    assign pop_ok  = pop_i & ~empty;
    // A pop in the same cycle frees a slot, so a full queue still accepts.
    assign push_ok = push_i & (~full | pop_ok);
    assign rd_nxt  = rd_q + 1'b1;

    always_comb begin
        level_d = level_q;
        if (push_ok && !pop_ok)
            level_d = level_q + 1'b1;
        else if (!push_ok && pop_ok)
            level_d = level_q - 1'b1;
    end

    always_comb begin
        head_d = head_q;
        if (empty) begin
            if (push_ok)
                head_d = din_i;
        end else if (pop_ok) begin
            // Last entry leaving: the successor is either the incoming push or nothing.
            if (level_q == LW'(1)) begin
                if (push_ok)
                    head_d = din_i;
            end else begin
                head_d = mem_q[rd_nxt];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
            head_q  <= '0;
        end else begin
            if (push_ok)
                wr_q <= wr_q + 1'b1;
            if (pop_ok)
                rd_q <= rd_nxt;
            level_q <= level_d;
            head_q  <= head_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok)
            mem_q[wr_q] <= din_i;
    end

    assign dout_o    = head_q;
    assign valid_o   = ~empty;
    assign full_o    = full;
    assign push_ok_o = push_ok;
    assign level_o   = level_q;

endmodule

// File: rtl/pulse_width_capture.sv
// Pulse-width counter fed by the control FSM strobes; finished widths go into
// a FWFT queue, with sticky overflow and a saturating drop counter.
module pulse_width_capture
    import pulse_count_pkg::*;
#(
    parameter int CNT_W  = DEF_CNT_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int DROP_W = DEF_DROP_W
) (
    input  logic                     SYS_CLK,
    input  logic                     A_RESET_N,
    input  logic                     INC,
    input  logic                     SCLR,
    input  logic                     LOAD,
    input  logic                     CLR_STAT,
    input  logic                     OUT_READY,
    output logic                     OUT_VALID,
    output logic [CNT_W-1:0]         OUT_WIDTH,
    output logic                     OUT_SAT,
    output logic [$clog2(DEPTH):0]   LEVEL,
    output logic                     OVF,
    output logic [DROP_W-1:0]        DROP_CNT
);

    typedef struct packed {
        logic             sat;
        logic [CNT_W-1:0] width;
    } entry_t;

    strobe_e           stb;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              sat_q, sat_d;
    logic              ovf_q, ovf_d;
    logic [DROP_W-1:0] drop_q, drop_d;
    logic              push, pop, drop, full, push_ok;
    entry_t            push_ent, head_ent;

    assign stb = strobe_decode(SCLR, LOAD, INC);

    always_comb begin
        cnt_d = cnt_q;
        sat_d = sat_q;
        case (stb)
            STB_CLR: begin
                cnt_d = '0;
                sat_d = 1'b0;
            end
            STB_INC: begin
                if (&cnt_q)
                    sat_d = 1'b1;
                else
                    cnt_d = cnt_q + 1'b1;
            end
            default: ;
        endcase
    end

    assign push           = (stb == STB_CAP);
    assign pop            = OUT_VALID & OUT_READY;
    assign push_ent.sat   = sat_q;
    assign push_ent.width = cnt_q;
    assign drop           = push & ~push_ok;

    // A drop beats a coincident CLR_STAT, leaving exactly one counted drop.
    always_comb begin
        ovf_d  = ovf_q;
        drop_d = drop_q;
        if (drop) begin
            ovf_d  = 1'b1;
            if (CLR_STAT)
                drop_d = DROP_W'(1);
            else if (!(&drop_q))
                drop_d = drop_q + 1'b1;
        end else if (CLR_STAT) begin
            ovf_d  = 1'b0;
            drop_d = '0;
        end
    end

    always_ff @(posedge SYS_CLK or negedge A_RESET_N) begin
        if (!A_RESET_N) begin
            cnt_q  <= '0;
            sat_q  <= 1'b0;
            ovf_q  <= 1'b0;
            drop_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            sat_q  <= sat_d;
            ovf_q  <= ovf_d;
            drop_q <= drop_d;
        end
    end

    pulse_fifo #(
        .W     (CNT_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i     (SYS_CLK),
        .rst_n_i   (A_RESET_N),
        .push_i    (push),
        .din_i     (push_ent),
        .pop_i     (pop),
        .dout_o    (head_ent),
        .valid_o   (OUT_VALID),
        .full_o    (full),
        .push_ok_o (push_ok),
        .level_o   (LEVEL)
    );

    assign OUT_WIDTH = head_ent.width;
    assign OUT_SAT   = head_ent.sat;
    assign OVF       = ovf_q;
    assign DROP_CNT  = drop_q;

endmodule

// File: tb/tb_pulse_width_capture.sv
// Bench for pulse_width_capture at CNT_W=4, DEPTH=4: directed scenarios plus
// random strobes against a queue-based reference model.
module tb_pulse_width_capture;

    localparam int CNT_W  = 4;
    localparam int DEPTH  = 4;
    localparam int DROP_W = 8;
    localparam int WMAX   = (1 << CNT_W) - 1;
    localparam int DMAX   = (1 << DROP_W) - 1;

    logic                   SYS_CLK = 1'b0;
    logic                   A_RESET_N;
    logic                   INC, SCLR, LOAD, CLR_STAT, OUT_READY;
    logic                   OUT_VALID, OUT_SAT, OVF;
    logic [CNT_W-1:0]       OUT_WIDTH;
    logic [$clog2(DEPTH):0] LEVEL;
    logic [DROP_W-1:0]      DROP_CNT;

    int checks = 0;
    int errors = 0;

    pulse_width_capture #(.CNT_W(CNT_W), .DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
        .SYS_CLK   (SYS_CLK),
        .A_RESET_N (A_RESET_N),
        .INC       (INC),
        .SCLR      (SCLR),
        .LOAD      (LOAD),
        .CLR_STAT  (CLR_STAT),
        .OUT_READY (OUT_READY),
        .OUT_VALID (OUT_VALID),
        .OUT_WIDTH (OUT_WIDTH),
        .OUT_SAT   (OUT_SAT),
        .LEVEL     (LEVEL),
        .OVF       (OVF),
        .DROP_CNT  (DROP_CNT)
    );

    always #5 SYS_CLK = ~SYS_CLK;

    // Reference model: count of INC cycles since last clear, a queue of
    // captured results, and the drop statistics.
    typedef struct { int w; bit s; } ent_t;
    ent_t mq[$];
    ent_t shown;
    int   m_cnt, m_drops;
    bit   m_ovf;

    function automatic void model_reset();
        mq.delete();
        shown   = '{0, 1'b0};
        m_cnt   = 0;
        m_drops = 0;
        m_ovf   = 1'b0;
    endfunction

    function automatic void model_edge(bit inc, bit sclr, bit load, bit rdy, bit clr);
        int sz = mq.size();
        bit popped = rdy && (sz > 0);
        ent_t e;
        if (popped) void'(mq.pop_front());
        if (load && !sclr) begin
            e.w = (m_cnt > WMAX) ? WMAX : m_cnt;
            e.s = (m_cnt > WMAX);
            if (sz < DEPTH || popped) begin
                mq.push_back(e);
            end else begin
                m_ovf   = 1'b1;
                m_drops = clr ? 1 : ((m_drops < DMAX) ? m_drops + 1 : DMAX);
            end
        end else if (clr) begin
            m_ovf   = 1'b0;
            m_drops = 0;
        end
        if (load && !sclr && clr && !(sz < DEPTH || popped)) begin
            // drop already recorded above, clear suppressed
        end else if (load && !sclr && clr) begin
            m_ovf   = 1'b0;
            m_drops = 0;
        end
        if (sclr)          m_cnt = 0;
        else if (!load && inc) m_cnt = m_cnt + 1;
        if (mq.size() > 0) shown = mq[0];
    endfunction

    task automatic step(input bit inc, input bit sclr, input bit load,
                        input bit rdy, input bit clr);
        INC = inc; SCLR = sclr; LOAD = load; OUT_READY = rdy; CLR_STAT = clr;
        @(posedge SYS_CLK);
        model_edge(inc, sclr, load, rdy, clr);
        #1;
        INC = 0; SCLR = 0; LOAD = 0; OUT_READY = 0; CLR_STAT = 0;
    endtask

    task automatic pulse(input int n, input bit rdy);
        step(0, 1, 0, rdy, 0);
        for (int i = 0; i < n; i++) step(1, 0, 0, rdy, 0);
        step(0, 0, 1, rdy, 0);
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 1; i++) step(0, 0, 0, 1, 0);
    endtask

    task automatic test_reset();
        checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b exp 0", OUT_VALID); end
        checks++; if (OUT_WIDTH !== '0) begin errors++; $display("FAIL reset_width: got %0d exp 0", OUT_WIDTH); end
        checks++; if (OUT_SAT !== 1'b0) begin errors++; $display("FAIL reset_sat: got %0b exp 0", OUT_SAT); end
        checks++; if (LEVEL !== '0) begin errors++; $display("FAIL reset_level: got %0d exp 0", LEVEL); end
        checks++; if (OVF !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %0b exp 0", OVF); end
        checks++; if (DROP_CNT !== '0) begin errors++; $display("FAIL reset_drop: got %0d exp 0", DROP_CNT); end
    endtask

    task automatic test_basic();
        pulse(5, 0);
        checks++; if (OUT_VALID !== 1'b1) begin errors++; $display("FAIL basic_valid: got %0b exp 1", OUT_VALID); end
        checks++; if (OUT_WIDTH !== 4'd5) begin errors++; $display("FAIL basic_width: got %0d exp 5", OUT_WIDTH); end
        checks++; if (OUT_SAT !== 1'b0) begin errors++; $display("FAIL basic_sat: got %0b exp 0", OUT_SAT); end
        checks++; if (LEVEL !== 3'd1) begin errors++; $display("FAIL basic_level: got %0d exp 1", LEVEL); end
        step(0, 0, 0, 1, 0);
        checks++; if (LEVEL !== 3'd0 || OUT_VALID !== 1'b0) begin errors++; $display("FAIL basic_pop: got level %0d valid %0b exp 0 0", LEVEL, OUT_VALID); end
        checks++; if (OUT_WIDTH !== 4'd5) begin errors++; $display("FAIL basic_hold: got %0d exp 5", OUT_WIDTH); end
    endtask

    task automatic test_saturation();
        pulse(20, 0);
        checks++; if (OUT_WIDTH !== 4'd15 || OUT_SAT !== 1'b1) begin errors++; $display("FAIL sat_long: got %0d/%0b exp 15/1", OUT_WIDTH, OUT_SAT); end
        step(0, 0, 0, 1, 0);
        pulse(3, 0);
        checks++; if (OUT_WIDTH !== 4'd3 || OUT_SAT !== 1'b0) begin errors++; $display("FAIL sat_clear: got %0d/%0b exp 3/0", OUT_WIDTH, OUT_SAT); end
        drain();
    endtask

    task automatic test_overflow();
        for (int n = 1; n <= 6; n++) pulse(n, 0);
        checks++; if (LEVEL !== 3'd4) begin errors++; $display("FAIL ovf_level: got %0d exp 4", LEVEL); end
        checks++; if (OVF !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %0b exp 1", OVF); end
        checks++; if (DROP_CNT !== 8'd2) begin errors++; $display("FAIL ovf_drops: got %0d exp 2", DROP_CNT); end
        for (int i = 1; i <= 4; i++) begin
            checks++; if (int'(OUT_WIDTH) !== i || OUT_VALID !== 1'b1) begin errors++; $display("FAIL ovf_order: got %0d exp %0d", OUT_WIDTH, i); end
            step(0, 0, 0, 1, 0);
        end
        checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL ovf_drained: got %0b exp 0", OUT_VALID); end
    endtask

    task automatic test_full_pop();
        int exp_head[4] = '{3, 4, 5, 7};
        for (int n = 2; n <= 5; n++) pulse(n, 0);
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 7; i++) step(1, 0, 0, 0, 0);
        step(0, 0, 1, 1, 0);
        checks++; if (LEVEL !== 3'd4) begin errors++; $display("FAIL fullpop_level: got %0d exp 4", LEVEL); end
        checks++; if (DROP_CNT !== 8'd2) begin errors++; $display("FAIL fullpop_nodrop: got %0d exp 2", DROP_CNT); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (int'(OUT_WIDTH) !== exp_head[i]) begin errors++; $display("FAIL fullpop_order: got %0d exp %0d", OUT_WIDTH, exp_head[i]); end
            step(0, 0, 0, 1, 0);
        end
        // drop coinciding with CLR_STAT leaves one counted drop
        for (int n = 1; n <= 4; n++) pulse(n, 0);
        step(0, 0, 1, 0, 1);
        checks++; if (OVF !== 1'b1 || DROP_CNT !== 8'd1) begin errors++; $display("FAIL clrstat_drop: got %0b/%0d exp 1/1", OVF, DROP_CNT); end
        step(0, 0, 0, 0, 1);
        checks++; if (OVF !== 1'b0 || DROP_CNT !== 8'd0) begin errors++; $display("FAIL clrstat: got %0b/%0d exp 0/0", OVF, DROP_CNT); end
        drain();
    endtask

    task automatic test_priority();
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0);
        checks++; if (OUT_WIDTH !== 4'd3 || LEVEL !== 3'd1) begin errors++; $display("FAIL prio_incload: got %0d lvl %0d exp 3 lvl 1", OUT_WIDTH, LEVEL); end
        step(0, 0, 0, 1, 0);
        step(0, 1, 1, 0, 0);
        checks++; if (LEVEL !== 3'd0 || OUT_VALID !== 1'b0) begin errors++; $display("FAIL prio_sclrload: got lvl %0d exp 0", LEVEL); end
        step(0, 0, 1, 0, 0);
        checks++; if (OUT_WIDTH !== 4'd0 || OUT_VALID !== 1'b1) begin errors++; $display("FAIL prio_cleared: got %0d exp 0", OUT_WIDTH); end
        drain();
    endtask

    task automatic test_async_reset();
        for (int n = 0; n < 5; n++) pulse(1, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        checks++; if (LEVEL !== 3'd2 || OVF !== 1'b1) begin errors++; $display("FAIL arst_setup: got lvl %0d ovf %0b exp 2 1", LEVEL, OVF); end
        step(0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        INC = 1;
        #2 A_RESET_N = 0;
        #1;
        model_reset();
        test_reset();
        INC = 0;
        #2 A_RESET_N = 1;
        pulse(4, 0);
        checks++; if (OUT_WIDTH !== 4'd4 || OUT_VALID !== 1'b1) begin errors++; $display("FAIL arst_after: got %0d exp 4", OUT_WIDTH); end
        drain();
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            int r = $urandom_range(0, 99);
            bit inc  = (r < 70) || ($urandom_range(0, 15) == 0);
            bit sclr = (r >= 70 && r < 77) || ($urandom_range(0, 30) == 0);
            bit load = (r >= 77 && r < 92) || ($urandom_range(0, 30) == 0);
            bit clr  = ($urandom_range(0, 40) == 0);
            bit rdy  = ((c / 64) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 5) == 0);
            step(inc, sclr, load, rdy, clr);
            checks++;
            if (OUT_VALID !== (mq.size() > 0) || int'(LEVEL) !== mq.size() ||
                int'(OUT_WIDTH) !== shown.w || OUT_SAT !== shown.s ||
                OVF !== m_ovf || int'(DROP_CNT) !== m_drops) begin
                errors++;
                $display("FAIL random_c%0d: got v%0b l%0d w%0d s%0b o%0b d%0d exp v%0b l%0d w%0d s%0b o%0b d%0d",
                         c, OUT_VALID, LEVEL, OUT_WIDTH, OUT_SAT, OVF, DROP_CNT,
                         mq.size() > 0, mq.size(), shown.w, shown.s, m_ovf, m_drops);
            end
        end
    endtask

    initial begin
        A_RESET_N = 0;
        INC = 0; SCLR = 0; LOAD = 0; CLR_STAT = 0; OUT_READY = 0;
        model_reset();
        repeat (2) @(posedge SYS_CLK);
        #1;
        test_reset();
        #2 A_RESET_N = 1;
        test_basic();
        test_saturation();
        test_overflow();
        test_full_pop();
        test_priority();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
